// File: rtl/grf_hilo_mdu.sv
// 2R/1W register file with write-first bypass plus a multi-cycle mult/div sequencer owning HI/LO.
// Define GRF_TRACE_EN to compile simulation-only commit trace messages.
module grf_hilo_mdu #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [31:0]       pc,
    input  logic              md_start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] md_a,
    input  logic [DATA_W-1:0] md_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] mt_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] a_reg, b_reg, hi_reg, lo_reg;
    logic [1:0]        op_reg;
    logic              busy_reg;
    logic [DATA_W-1:0] regs [DEPTH];

    logic [DATA_W-1:0]   res_hi, res_lo;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;
    logic signed [DATA_W-1:0] sq, sr;

    // ---------------- register file ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    logic [ADDR_W-1:0] ra_v [2];
    logic [DATA_W-1:0] rd_v [2];
    assign ra_v[0] = ra1;
    assign ra_v[1] = ra2;

    // Write-first bypass so ID sees the value WB is committing this cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        always_comb begin
            rd_v[gi] = '0;
            if (ra_v[gi] != '0)
                rd_v[gi] = (we && wa == ra_v[gi]) ? wd : regs[ra_v[gi]];
        end
    end
    assign rd1 = rd_v[0];
    assign rd2 = rd_v[1];

    // ---------------- result datapath ----------------
    always_comb begin
        ext_a  = op_reg[0] ? {{DATA_W{1'b0}}, a_reg} : {{DATA_W{a_reg[DATA_W-1]}}, a_reg};
        ext_b  = op_reg[0] ? {{DATA_W{1'b0}}, b_reg} : {{DATA_W{b_reg[DATA_W-1]}}, b_reg};
        prod   = ext_a * ext_b;
        sq     = $signed(a_reg) / $signed(b_reg);
        sr     = $signed(a_reg) % $signed(b_reg);
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (op_reg[1]) begin
            if (b_reg == '0) begin
                res_hi = a_reg;
                res_lo = '1;
            end else if (!op_reg[0] && a_reg == {1'b1, {(DATA_W-1){1'b0}}} && b_reg == '1) begin
                res_hi = '0;
                res_lo = a_reg;
            end else if (!op_reg[0]) begin
                res_hi = sr;
                res_lo = sq;
            end else begin
                res_hi = a_reg % b_reg;
                res_lo = a_reg / b_reg;
            end
        end
    end

    // ---------------- sequencer and HI/LO ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (md_start) begin
                        a_reg     <= md_a;
                        b_reg     <= md_b;
                        op_reg    <= md_op;
                        cnt_reg   <= md_op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                        state_reg <= S_RUN;
                        busy_reg  <= 1'b1;
                    end else begin
                        if (hi_we) hi_reg <= mt_data;
                        if (lo_we) lo_reg <= mt_data;
                    end
                end
                S_RUN: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        hi_reg    <= res_hi;
                        lo_reg    <= res_lo;
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign hi   = (!busy_reg && hi_we) ? mt_data : hi_reg;
    assign lo   = (!busy_reg && lo_we) ? mt_data : lo_reg;
    assign busy = busy_reg;

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (reset_n) begin
            if (we && wa != '0)
                $display("%0t@%h: $%0d <= %h", $time, pc, wa, wd);
            if (state_reg == S_RUN && cnt_reg == CNT_W'(1)) begin
                $display("%0t@hi: <= %h", $time, res_hi);
                $display("%0t@lo: <= %h", $time, res_lo);
            end else if (state_reg == S_IDLE && !md_start) begin
                if (hi_we) $display("%0t@hi: <= %h", $time, mt_data);
                if (lo_we) $display("%0t@lo: <= %h", $time, mt_data);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif
endmodule

// File: tb/tb_grf_hilo_mdu.sv
// Directed bench for grf_hilo_mdu: register file bypass, mult/div results, collisions and reset abort.
module tb_grf_hilo_mdu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
    logic [31:0] rd1, rd2, wd = '0, pc = '0;
    logic        we = 1'b0;
    logic        md_start = 1'b0;
    logic [1:0]  md_op = '0;
    logic [31:0] md_a = '0, md_b = '0, mt_data = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] hi, lo;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    grf_hilo_mdu #(.DATA_W(32), .ADDR_W(5), .MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .pc(pc),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .hi_we(hi_we), .lo_we(lo_we), .mt_data(mt_data),
        .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start = 1'b1; md_op = op; md_a = a; md_b = b;
        smp();
        chk("busy_before_start", {31'b0, busy}, 32'h0);
        tick();
        md_start = 1'b0;
    endtask

    task automatic wait_busy(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            smp();
            chk(tag, {31'b0, busy}, 32'h1);
            tick();
        end
        smp();
    endtask

    task automatic chk_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        repeat (2) tick();
        reset_n = 1'b1;
        ra2 = 5'd5;
        smp();
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk_done("rst", 32'h0, 32'h0);

        // register write with same-cycle bypass
        tick();
        we = 1'b1; wa = 5'd3; wd = 32'h1234ABCD; ra1 = 5'd3; pc = 32'h0040_0000;
        smp();
        chk("bypass_rd1", rd1, 32'h1234ABCD);
        tick();
        we = 1'b0; ra2 = 5'd3;
        smp();
        chk("stored_rd1", rd1, 32'h1234ABCD);
        chk("stored_rd2", rd2, 32'h1234ABCD);
        tick();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0;
        smp();
        chk("r0_bypass", rd1, 32'h0);
        tick();
        we = 1'b0;
        smp();
        chk("r0_stored", rd1, 32'h0);
        chk("r3_intact", rd2, 32'h1234ABCD);
        tick();

        // multiply / divide results
        start_op(2'b00, 32'hFFFFFFFE, 32'd3);
        wait_busy(5, "mult_busy");
        chk_done("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        tick();
        start_op(2'b01, 32'hFFFFFFFE, 32'd3);
        wait_busy(5, "multu_busy");
        chk_done("multu", 32'h00000002, 32'hFFFFFFFA);
        tick();
        start_op(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_busy(10, "div_busy");
        chk_done("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        tick();
        start_op(2'b11, 32'd5, 32'd0);
        wait_busy(10, "divz_busy");
        chk_done("divz", 32'h00000005, 32'hFFFFFFFF);
        tick();

        // start and mthi while running are ignored; old HI/LO shown until commit
        start_op(2'b11, 32'd100, 32'd7);
        md_start = 1'b1; md_op = 2'b00; md_a = 32'd2; md_b = 32'd2;
        hi_we = 1'b1; mt_data = 32'h55;
        smp();
        chk("coll_busy", {31'b0, busy}, 32'h1);
        chk("coll_hi_old", hi, 32'h00000005);
        chk("coll_lo_old", lo, 32'hFFFFFFFF);
        tick();
        md_start = 1'b0; hi_we = 1'b0;
        wait_busy(9, "coll_run_busy");
        chk_done("coll_divu", 32'h00000002, 32'h0000000E);
        tick();

        start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_busy(10, "ovf_busy");
        chk_done("ovf", 32'h00000000, 32'h80000000);
        tick();

        // mthi/mtlo while idle
        hi_we = 1'b1; mt_data = 32'hAA;
        smp();
        chk("mthi_comb", hi, 32'hAA);
        chk("mthi_lo_keep", lo, 32'h80000000);
        tick();
        hi_we = 1'b0;
        smp();
        chk("mthi_stored", hi, 32'hAA);
        tick();
        hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'h77;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        smp();
        chk_done("mt_both", 32'h77, 32'h77);
        tick();

        // start wins over mtlo in the same cycle
        md_start = 1'b1; md_op = 2'b01; md_a = 32'd3; md_b = 32'd4;
        lo_we = 1'b1; mt_data = 32'h99;
        tick();
        md_start = 1'b0; lo_we = 1'b0;
        wait_busy(5, "startwin_busy");
        chk_done("startwin", 32'h0, 32'h0000000C);
        tick();

        // reset mid-divide aborts the operation
        hi_we = 1'b1; mt_data = 32'h11;
        tick();
        hi_we = 1'b0;
        ra1 = 5'd3;
        start_op(2'b10, 32'd100, 32'd7);
        repeat (6) tick();
        chk("pre_rst_busy", {31'b0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk_done("abort", 32'h0, 32'h0);
        chk("abort_rd1", rd1, 32'h0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            smp();
            chk("post_rst_idle", {31'b0, busy}, 32'h0);
            tick();
        end
        smp();
        chk_done("post_rst", 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
